// File: rtl/adc_scan_ctrl_if.sv
// adc_scan_ctrl_if
//   Handshake bundle between adc_scan_ctrl and the ADC128S102 SPI frame driver.
//   o_adc_start : single-cycle pulse, begin one 16-SCLK frame
//   o_adc_addr  : channel address shifted out during the frame
//   i_adc_done  : single-cycle pulse, frame complete
//   i_adc_data  : 12-bit frame result, valid with i_adc_done
//   The o_/i_ prefixes are as seen from the scheduler (master) side.
`timescale 1ns/1ps
interface adc_scan_ctrl_if;
    logic        o_adc_start;
    logic [2:0]  o_adc_addr;
    logic        i_adc_done;
    logic [11:0] i_adc_data;

    modport master (
        output o_adc_start,
        output o_adc_addr,
        input  i_adc_done,
        input  i_adc_data
    );

    modport slave (
        input  o_adc_start,
        input  o_adc_addr,
        output i_adc_done,
        output i_adc_data
    );
endinterface

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl
//   Conversion scheduler in front of the ADC128S102 SPI driver. Runs periodic
//   scans over a channel mask and serves on-demand single-channel requests
//   (requests win over the scan). The ADC returns, in each frame, the data of
//   the channel addressed in the previous frame; this block tracks that
//   pipeline and tags every published result with its true channel.
//
//   Ports
//     i_clk, i_rst_n   : clock, asynchronous active-low reset
//     i_scan_en        : enables the scan period counter (low holds it at 0)
//     i_ch_mask        : channels included in a scan (bit n = IN n)
//     i_req, i_req_ch  : single-cycle on-demand request and its channel
//     o_req_busy       : request accepted, result not yet published
//     adc              : driver handshake (start/addr out, done/data in)
//     o_result_valid   : single-cycle result strobe
//     o_result_ch/data : result channel tag and value (held until next result)
//     o_scan_done      : pulses with the result of the last masked channel
//     o_overrun        : pulses when a scan trigger is dropped
`timescale 1ns/1ps
module adc_scan_ctrl #(
    parameter int unsigned SCAN_PERIOD = 50_000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_scan_en,
    input  logic [7:0]             i_ch_mask,
    input  logic                   i_req,
    input  logic [2:0]             i_req_ch,
    output logic                   o_req_busy,
    adc_scan_ctrl_if.master        adc,
    output logic                   o_result_valid,
    output logic [2:0]             o_result_ch,
    output logic [11:0]            o_result_data,
    output logic                   o_scan_done,
    output logic                   o_overrun
);

    localparam int unsigned CW = $clog2(SCAN_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_PUBLISH
    } state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic        active_q, active_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  idx_q, idx_d;
    logic        flush_next_q, flush_next_d;   // next scan frame is the flush frame
    logic        frame_flush_q, frame_flush_d; // frame in flight is the flush frame
    logic [2:0]  addr_q, addr_d;
    logic        busy_q, busy_d;
    logic [2:0]  req_ch_q, req_ch_d;
    logic [2:0]  prev_addr_q, prev_addr_d;
    logic        prev_valid_q, prev_valid_d;
    logic        res_valid_q, res_valid_d;
    logic [2:0]  res_ch_q, res_ch_d;
    logic [11:0] res_data_q, res_data_d;
    logic        scan_done_q, scan_done_d;
    logic        overrun_q, overrun_d;

    logic        wrap;
    logic        mask_nz;
    logic        low_found;
    logic [2:0]  low_idx;
    logic        nxt_found;
    logic [2:0]  nxt_idx;

    assign wrap    = i_scan_en && (cnt_q == CW'(SCAN_PERIOD - 1));
    assign mask_nz = |i_ch_mask;

    // Lowest set bit of the live mask (scan start) and next set bit of the
    // latched mask above the current index (scan advance).
    always_comb begin
        low_found = 1'b0;
        low_idx   = '0;
        nxt_found = 1'b0;
        nxt_idx   = idx_q;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!low_found && i_ch_mask[i]) begin
                low_found = 1'b1;
                low_idx   = 3'(i);
            end
            if (!nxt_found && (i > 32'(idx_q)) && mask_q[i]) begin
                nxt_found = 1'b1;
                nxt_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pending_d     = pending_q;
        active_d      = active_q;
        mask_d        = mask_q;
        idx_d         = idx_q;
        flush_next_d  = flush_next_q;
        frame_flush_d = frame_flush_q;
        addr_d        = addr_q;
        busy_d        = busy_q;
        req_ch_d      = req_ch_q;
        prev_addr_d   = prev_addr_q;
        prev_valid_d  = prev_valid_q;
        res_valid_d   = 1'b0;
        res_ch_d      = res_ch_q;
        res_data_d    = res_data_q;
        scan_done_d   = 1'b0;
        overrun_d     = 1'b0;

        // Period counter; the wrap is the scan trigger.
        if (!i_scan_en) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        if (wrap && mask_nz) begin
            if (pending_q || active_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        if (i_req && !busy_q) begin
            busy_d   = 1'b1;
            req_ch_d = i_req_ch;
        end

        case (state_q)
            S_IDLE: begin
                if (busy_q) begin
                    addr_d        = req_ch_q;
                    frame_flush_d = 1'b0;
                    state_d       = S_START;
                end else if (active_q) begin
                    addr_d        = idx_q;
                    frame_flush_d = flush_next_q;
                    state_d       = S_START;
                    // Past the highest masked channel, idx stays put so the
                    // flush frame re-addresses it.
                    if (!flush_next_q) begin
                        if (nxt_found) begin
                            idx_d = nxt_idx;
                        end else begin
                            flush_next_d = 1'b1;
                        end
                    end
                end else if (pending_q) begin
                    pending_d = 1'b0;
                    mask_d    = i_ch_mask;
                    if (mask_nz) begin
                        active_d     = 1'b1;
                        idx_d        = low_idx;
                        flush_next_d = 1'b0;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (adc.i_adc_done) begin
                    state_d      = S_PUBLISH;
                    prev_addr_d  = addr_q;
                    prev_valid_d = 1'b1;
                    // The data returned belongs to the previously addressed channel.
                    if (prev_valid_q) begin
                        res_valid_d = 1'b1;
                        res_ch_d    = prev_addr_q;
                        res_data_d  = adc.i_adc_data;
                        scan_done_d = frame_flush_q;
                        if (busy_q && (prev_addr_q == req_ch_q)) begin
                            busy_d = 1'b0;
                        end
                    end
                    if (frame_flush_q) begin
                        active_d = 1'b0;
                    end
                end
            end
            S_PUBLISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            active_q      <= 1'b0;
            mask_q        <= '0;
            idx_q         <= '0;
            flush_next_q  <= 1'b0;
            frame_flush_q <= 1'b0;
            addr_q        <= '0;
            busy_q        <= 1'b0;
            req_ch_q      <= '0;
            prev_addr_q   <= '0;
            prev_valid_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            res_ch_q      <= '0;
            res_data_q    <= '0;
            scan_done_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            active_q      <= active_d;
            mask_q        <= mask_d;
            idx_q         <= idx_d;
            flush_next_q  <= flush_next_d;
            frame_flush_q <= frame_flush_d;
            addr_q        <= addr_d;
            busy_q        <= busy_d;
            req_ch_q      <= req_ch_d;
            prev_addr_q   <= prev_addr_d;
            prev_valid_q  <= prev_valid_d;
            res_valid_q   <= res_valid_d;
            res_ch_q      <= res_ch_d;
            res_data_q    <= res_data_d;
            scan_done_q   <= scan_done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign adc.o_adc_start = (state_q == S_START);
    assign adc.o_adc_addr  = addr_q;
    assign o_req_busy      = busy_q;
    assign o_result_valid  = res_valid_q;
    assign o_result_ch     = res_ch_q;
    assign o_result_data   = res_data_q;
    assign o_scan_done     = scan_done_q;
    assign o_overrun       = overrun_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl
//   Scoreboard bench for adc_scan_ctrl. Stimulus pushes expected frame
//   addresses and expected results into queues; a negedge monitor pops and
//   compares whenever the DUT starts a frame or strobes a result. A simple
//   driver model answers each frame after a programmable delay.
`timescale 1ns/1ps
module tb_adc_scan_ctrl;
    localparam int unsigned PERIOD = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_en = 1'b0;
    logic [7:0]  mask = '0;
    logic        req = 1'b0;
    logic [2:0]  req_ch = '0;
    logic        req_busy;
    logic        res_valid;
    logic [2:0]  res_ch;
    logic [11:0] res_data;
    logic        scan_done;
    logic        overrun;

    adc_scan_ctrl_if adc();

    adc_scan_ctrl #(.SCAN_PERIOD(PERIOD)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_scan_en      (scan_en),
        .i_ch_mask      (mask),
        .i_req          (req),
        .i_req_ch       (req_ch),
        .o_req_busy     (req_busy),
        .adc            (adc),
        .o_result_valid (res_valid),
        .o_result_ch    (res_ch),
        .o_result_data  (res_data),
        .o_scan_done    (scan_done),
        .o_overrun      (overrun)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] data;
        logic        sd;
        logic        busy;
    } res_t;

    res_t        exp_res_q[$];
    logic [2:0]  exp_addr_q[$];
    logic [11:0] data_q[$];
    res_t        mon_e;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned done_cyc = 0;
    int unsigned ovr_cnt = 0;
    int unsigned ovr_base = 0;
    int unsigned dly = 3;
    bit          drv_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_res(input logic [2:0] ch, input logic [11:0] d, input logic sd, input logic busy);
        res_t e;
        e.ch = ch; e.data = d; e.sd = sd; e.busy = busy;
        exp_res_q.push_back(e);
    endtask

    // Driver model: answer each frame start after dly cycles.
    initial begin
        adc.i_adc_done = 1'b0;
        adc.i_adc_data = '0;
        forever begin
            @(negedge clk);
            if (adc.o_adc_start) begin
                drv_busy = 1'b1;
                repeat (dly) @(posedge clk);
                #1;
                if (data_q.size() > 0) adc.i_adc_data = data_q.pop_front();
                else                   adc.i_adc_data = 12'hFFF;
                adc.i_adc_done = 1'b1;
                done_cyc = cyc;
                @(posedge clk);
                #1;
                adc.i_adc_done = 1'b0;
                drv_busy = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (adc.o_adc_start) begin
            if (exp_addr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_start: addr=%0d, none expected (cycle %0d)", adc.o_adc_addr, cyc);
            end else begin
                chk("adc_addr", 32'(adc.o_adc_addr), 32'(exp_addr_q.pop_front()));
            end
        end
        if (res_valid) begin
            if (exp_res_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: ch=%0d data=%0h, none expected (cycle %0d)", res_ch, res_data, cyc);
            end else begin
                mon_e = exp_res_q.pop_front();
                chk("result_ch", 32'(res_ch), 32'(mon_e.ch));
                chk("result_data", 32'(res_data), 32'(mon_e.data));
                chk("scan_done", 32'(scan_done), 32'(mon_e.sd));
                chk("req_busy_at_result", 32'(req_busy), 32'(mon_e.busy));
                chk("result_latency", cyc, done_cyc + 1);
            end
        end else if (scan_done) begin
            checks++; errors++;
            $display("FAIL stray_scan_done: scan_done=1 without result (cycle %0d)", cyc);
        end
    end

    task automatic trigger_one();
        @(posedge clk); #1 scan_en = 1'b1;
        repeat (PERIOD) @(posedge clk);
        #1 scan_en = 1'b0;
    endtask

    task automatic pulse_req(input logic [2:0] ch);
        @(posedge clk); #1 req = 1'b1; req_ch = ch;
        @(posedge clk); #1 req = 1'b0;
    endtask

    task automatic drain(input string name, input int unsigned budget);
        int unsigned n = 0;
        while ((exp_addr_q.size() > 0 || exp_res_q.size() > 0 || drv_busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_drain: addr_left=%0d res_left=%0d after %0d cycles", name,
                     exp_addr_q.size(), exp_res_q.size(), budget);
            exp_addr_q.delete();
            exp_res_q.delete();
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic wait_start(input logic [2:0] a, input int unsigned budget);
        int unsigned n = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (adc.o_adc_start && adc.o_adc_addr == a) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_start: no start for addr %0d within %0d cycles", a, budget);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_busy"}, 32'(req_busy), 0);
        chk({tag, "_adc_start"}, 32'(adc.o_adc_start), 0);
        chk({tag, "_adc_addr"}, 32'(adc.o_adc_addr), 0);
        chk({tag, "_result_valid"}, 32'(res_valid), 0);
        chk({tag, "_result_ch"}, 32'(res_ch), 0);
        chk({tag, "_result_data"}, 32'(res_data), 0);
        chk({tag, "_scan_done"}, 32'(scan_done), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset-first frame: first frame publishes nothing
        mask = 8'h01;
        data_q.push_back(12'hAAA); data_q.push_back(12'h555);
        exp_addr_q.push_back(3'd0); exp_addr_q.push_back(3'd0);
        exp_res(3'd0, 12'h555, 1'b1, 1'b0);
        trigger_one();
        drain("first_frame", 200);

        // Scan order over mask 1010_0100
        mask = 8'hA4;
        for (int i = 0; i < 4; i++) data_q.push_back(12'h100 + 12'(i));
        exp_addr_q.push_back(3'd2); exp_addr_q.push_back(3'd5);
        exp_addr_q.push_back(3'd7); exp_addr_q.push_back(3'd7);
        exp_res(3'd0, 12'h100, 1'b0, 1'b0);
        exp_res(3'd2, 12'h101, 1'b0, 1'b0);
        exp_res(3'd5, 12'h102, 1'b0, 1'b0);
        exp_res(3'd7, 12'h103, 1'b1, 1'b0);
        trigger_one();
        drain("scan_order", 300);

        // Mid-scan request for ch3 during the ch2 frame; a second request while busy is ignored
        mask = 8'h0F;
        for (int i = 0; i < 7; i++) data_q.push_back(12'h200 + 12'(i));
        exp_addr_q.push_back(3'd0); exp_addr_q.push_back(3'd1); exp_addr_q.push_back(3'd2);
        exp_addr_q.push_back(3'd3); exp_addr_q.push_back(3'd3);
        exp_addr_q.push_back(3'd3); exp_addr_q.push_back(3'd3);
        exp_res(3'd7, 12'h200, 1'b0, 1'b0);
        exp_res(3'd0, 12'h201, 1'b0, 1'b0);
        exp_res(3'd1, 12'h202, 1'b0, 1'b1);
        exp_res(3'd2, 12'h203, 1'b0, 1'b1);
        exp_res(3'd3, 12'h204, 1'b0, 1'b0);
        exp_res(3'd3, 12'h205, 1'b0, 1'b0);
        exp_res(3'd3, 12'h206, 1'b1, 1'b0);
        fork
            trigger_one();
            begin
                wait_start(3'd2, 200);
                @(posedge clk); #1 req = 1'b1; req_ch = 3'd3;
                @(posedge clk); #1 req_ch = 3'd5;
                @(posedge clk); #1 req = 1'b0;
            end
        join
        drain("mid_scan_req", 400);

        // Overrun: slow driver, counter kept running through the scan
        mask = 8'h01;
        dly = 400;
        data_q.push_back(12'h300); data_q.push_back(12'h301);
        exp_addr_q.push_back(3'd0); exp_addr_q.push_back(3'd0);
        exp_res(3'd3, 12'h300, 1'b0, 1'b0);
        exp_res(3'd0, 12'h301, 1'b1, 1'b0);
        ovr_base = ovr_cnt;
        @(posedge clk); #1 scan_en = 1'b1;
        repeat (830) @(posedge clk);
        #1 scan_en = 1'b0;
        drain("overrun", 2000);
        chk("overrun_count", ovr_cnt - ovr_base, 40);

        // Reset mid-frame with a request outstanding
        dly = 10;
        data_q.push_back(12'h777);
        exp_addr_q.push_back(3'd5);
        pulse_req(3'd5);
        wait_start(3'd5, 50);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        @(posedge clk); #1 rst_n = 1'b1;
        drain("stray_done", 100);
        dly = 3;
        data_q.push_back(12'h400); data_q.push_back(12'h401);
        exp_addr_q.push_back(3'd6); exp_addr_q.push_back(3'd6);
        exp_res(3'd6, 12'h401, 1'b0, 1'b0);
        pulse_req(3'd6);
        drain("post_reset", 200);

        // Scan ending on ch7, then an already-addressed request for ch7
        mask = 8'h80;
        data_q.push_back(12'h500); data_q.push_back(12'h501);
        exp_addr_q.push_back(3'd7); exp_addr_q.push_back(3'd7);
        exp_res(3'd6, 12'h500, 1'b0, 1'b0);
        exp_res(3'd7, 12'h501, 1'b1, 1'b0);
        trigger_one();
        drain("scan_ch7", 200);
        data_q.push_back(12'h502);
        exp_addr_q.push_back(3'd7);
        exp_res(3'd7, 12'h502, 1'b0, 1'b0);
        pulse_req(3'd7);
        drain("req_ch7", 100);

        // Empty mask: triggers ignored, no overrun
        mask = 8'h00;
        ovr_base = ovr_cnt;
        @(posedge clk); #1 scan_en = 1'b1;
        repeat (45) @(posedge clk);
        #1 scan_en = 1'b0;
        drain("mask_zero", 50);
        chk("mask_zero_overrun", ovr_cnt - ovr_base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
